dma_mem_responder: RTL and testbench

- Avalon-MM style slave memory that answers the DMA core's master-read and master-write ports.
- Serves as on-chip sample/result buffer and as the bench responder for DMA/FIR tests.
- Separate read and write slave ports: a read channel with pipelined fixed-latency data, and a write channel; both have programmable wait-state injection.
- Provides error flagging and transaction counters for verification.

---
 rtl/dma_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_dma_mem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_mem_responder.sv
// Avalon-MM style memory slave for DMA master read/write ports: fixed-latency
// pipelined reads, wait-state injection on both channels, sticky error flag and counters.
module dma_mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_PENDING  = 8,
  parameter int unsigned READ_WAIT    = 0,
  parameter int unsigned WRITE_WAIT   = 0
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [31:0] iAddress_Read,
  input  logic        iRead,
  output logic        oWaitRequest_Read,
  output logic [31:0] oReadData,
  output logic        oDataValid_Read,
  input  logic [31:0] iAddress_Write,
  input  logic        iWrite,
  input  logic [31:0] iWriteData,
  output logic        oWaitRequest_Write,
  input  logic        iStall,
  output logic        oErr,
  output logic [15:0] oReadCount,
  output logic [15:0] oWriteCount
);

  localparam int unsigned AW          = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  RD_WAIT_LIM = 4'(READ_WAIT);
  localparam logic [3:0]  WR_WAIT_LIM = 4'(WRITE_WAIT);
  localparam logic [3:0]  PEND_LIM    = 4'(MAX_PENDING);
  localparam logic [31:0] BAD_DATA    = 32'hDEAD_BEEF;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [3:0]  rwait_cnt_q, rwait_cnt_d;
  logic [3:0]  wwait_cnt_q, wwait_cnt_d;
  logic [3:0]  pending_q, pending_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [31:0] data_q [READ_LATENCY];
  logic [31:0] data_d [READ_LATENCY];
  logic [31:0] dchain [READ_LATENCY];
  logic        err_q, err_d;
  logic [15:0] read_cnt_q, read_cnt_d;
  logic [15:0] write_cnt_q, write_cnt_d;

  logic [31:0]   rd_off, wr_off;
  logic          rd_ok, wr_ok;
  logic [AW-1:0] rd_idx, wr_idx;
  logic [31:0]   rd_word;
  logic          dvalid;
  logic          rd_full, rd_ext_stall, rd_in_wait, rd_acc;
  logic          wr_in_wait, wr_acc;

  // Offset from BASE_ADDR is in range iff every bit above the word index is zero;
  // addresses below BASE wrap to large offsets and fail the same test.
  assign rd_off = iAddress_Read - BASE_ADDR;
  assign wr_off = iAddress_Write - BASE_ADDR;
  assign rd_ok  = (rd_off[31:AW+2] == '0) && (rd_off[1:0] == 2'b00);
  assign wr_ok  = (wr_off[31:AW+2] == '0) && (wr_off[1:0] == 2'b00);
  assign rd_idx = rd_off[AW+1:2];
  assign wr_idx = wr_off[AW+1:2];

  // Memory is read combinationally before the clocked write, giving read-before-write.
  assign rd_word = rd_ok ? mem_q[rd_idx] : BAD_DATA;

  assign dvalid = vld_q[READ_LATENCY-1];

  // A read leaving the pipeline this cycle frees its slot for a same-cycle accept.
  assign rd_full      = (pending_q - {3'b000, dvalid}) == PEND_LIM;
  assign rd_ext_stall = iStall | rd_full;
  assign rd_in_wait   = rwait_cnt_q != RD_WAIT_LIM;
  assign oWaitRequest_Read = iRead & (rd_ext_stall | rd_in_wait);
  assign rd_acc = iRead & ~oWaitRequest_Read;

  assign wr_in_wait = wwait_cnt_q != WR_WAIT_LIM;
  assign oWaitRequest_Write = iWrite & (iStall | wr_in_wait);
  assign wr_acc = iWrite & ~oWaitRequest_Write;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rwait_cnt_d = rwait_cnt_q;
    if (!iRead || rd_acc) begin
      rwait_cnt_d = '0;
    end else if (!rd_ext_stall && rd_in_wait) begin
      rwait_cnt_d = rwait_cnt_q + 4'd1;
    end

    wwait_cnt_d = wwait_cnt_q;
    if (!iWrite || wr_acc) begin
      wwait_cnt_d = '0;
    end else if (!iStall && wr_in_wait) begin
      wwait_cnt_d = wwait_cnt_q + 4'd1;
    end

    pending_d = pending_q;
    case ({rd_acc, dvalid})
      2'b10:   pending_d = pending_q + 4'd1;
      2'b01:   pending_d = pending_q - 4'd1;
      default: pending_d = pending_q;
    endcase

    vld_d     = '0;
    vld_d[0]  = rd_acc;
    dchain[0] = rd_word;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      dchain[i] = data_q[i-1];
    end
    // Each stage only loads when a valid word arrives, so the last stage holds
    // the previous read data while valid is low.
    for (int i = 0; i < READ_LATENCY; i++) begin
      data_d[i] = vld_d[i] ? dchain[i] : data_q[i];
    end

    err_d       = err_q | (rd_acc & ~rd_ok) | (wr_acc & ~wr_ok);
    read_cnt_d  = read_cnt_q + 16'(rd_acc);
    write_cnt_d = write_cnt_q + 16'(wr_acc);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rwait_cnt_q <= '0;
      wwait_cnt_q <= '0;
      pending_q   <= '0;
      vld_q       <= '0;
      err_q       <= 1'b0;
      read_cnt_q  <= '0;
      write_cnt_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) data_q[i] <= '0;
    end else begin
      rwait_cnt_q <= rwait_cnt_d;
      wwait_cnt_q <= wwait_cnt_d;
      pending_q   <= pending_d;
      vld_q       <= vld_d;
      err_q       <= err_d;
      read_cnt_q  <= read_cnt_d;
      write_cnt_q <= write_cnt_d;
      data_q      <= data_d;
    end
  end

  // NOTE: the memory array has no reset; contents survive iRst and the array
  // can map onto block/distributed RAM.
  always_ff @(posedge iClk) begin
    if (!iRst && wr_acc && wr_ok) begin
      mem_q[wr_idx] <= iWriteData;
    end
  end

  assign oReadData   = data_q[READ_LATENCY-1];
  assign oDataValid_Read = dvalid;
  assign oErr        = err_q;
  assign oReadCount  = read_cnt_q;
  assign oWriteCount = write_cnt_q;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench: three responders with different wait/latency/pending settings
// share one stimulus bus; each test checks the instance it targets.
module tb_dma_mem_responder;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [31:0] iAddress_Read = '0;
  logic        iRead = 1'b0;
  logic [31:0] iAddress_Write = '0;
  logic        iWrite = 1'b0;
  logic [31:0] iWriteData = '0;
  logic        iStall = 1'b0;

  logic        wr_a, ww_a, dv_a, err_a;
  logic [31:0] rd_a;
  logic [15:0] rc_a, wc_a;
  logic        wr_b, ww_b, dv_b, err_b;
  logic [31:0] rd_b;
  logic [15:0] rc_b, wc_b;
  logic        wr_c, ww_c, dv_c, err_c;
  logic [31:0] rd_c;
  logic [15:0] rc_c, wc_c;

  int total = 0;
  int bad   = 0;

  always #5 iClk = ~iClk;

  dma_mem_responder dut_a (
    .iClk(iClk), .iRst(iRst),
    .iAddress_Read(iAddress_Read), .iRead(iRead), .oWaitRequest_Read(wr_a),
    .oReadData(rd_a), .oDataValid_Read(dv_a),
    .iAddress_Write(iAddress_Write), .iWrite(iWrite), .iWriteData(iWriteData),
    .oWaitRequest_Write(ww_a), .iStall(iStall), .oErr(err_a),
    .oReadCount(rc_a), .oWriteCount(wc_a)
  );

  dma_mem_responder #(.READ_WAIT(3), .WRITE_WAIT(2)) dut_b (
    .iClk(iClk), .iRst(iRst),
    .iAddress_Read(iAddress_Read), .iRead(iRead), .oWaitRequest_Read(wr_b),
    .oReadData(rd_b), .oDataValid_Read(dv_b),
    .iAddress_Write(iAddress_Write), .iWrite(iWrite), .iWriteData(iWriteData),
    .oWaitRequest_Write(ww_b), .iStall(iStall), .oErr(err_b),
    .oReadCount(rc_b), .oWriteCount(wc_b)
  );

  dma_mem_responder #(.READ_LATENCY(4), .MAX_PENDING(1)) dut_c (
    .iClk(iClk), .iRst(iRst),
    .iAddress_Read(iAddress_Read), .iRead(iRead), .oWaitRequest_Read(wr_c),
    .oReadData(rd_c), .oDataValid_Read(dv_c),
    .iAddress_Write(iAddress_Write), .iWrite(iWrite), .iWriteData(iWriteData),
    .oWaitRequest_Write(ww_c), .iStall(iStall), .oErr(err_c),
    .oReadCount(rc_c), .oWriteCount(wc_c)
  );

  typedef struct {
    logic        rd;
    logic [31:0] raddr;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        exp_dv;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; checks land 3 ns later, well before the next edge.
  task automatic drive(input logic rd, input logic [31:0] raddr, input logic wr,
                       input logic [31:0] waddr, input logic [31:0] wdata, input logic stall);
    @(posedge iClk);
    #1;
    iRead = rd; iAddress_Read = raddr;
    iWrite = wr; iAddress_Write = waddr; iWriteData = wdata;
    iStall = stall;
    #3;
  endtask

  function automatic vec_t mk(input logic rd, input logic [31:0] raddr, input logic wr,
                              input logic [31:0] waddr, input logic [31:0] wdata,
                              input logic dv, input logic [31:0] rdata, input logic err);
    vec_t v;
    v.rd = rd; v.raddr = raddr; v.wr = wr; v.waddr = waddr; v.wdata = wdata;
    v.exp_dv = dv; v.exp_rdata = rdata; v.exp_err = err;
    return v;
  endfunction

  initial begin
    // writes, back-to-back reads, read-during-write, then out-of-range/misaligned access
    vecs[0]  = mk(0, 0,     1, 'h00, 'h1111_1111, 0, 'h0,         0);
    vecs[1]  = mk(0, 0,     1, 'h04, 'h2222_2222, 0, 'h0,         0);
    vecs[2]  = mk(0, 0,     1, 'h08, 'h3333_3333, 0, 'h0,         0);
    vecs[3]  = mk(0, 0,     1, 'h0C, 'h4444_4444, 0, 'h0,         0);
    vecs[4]  = mk(1, 'h00,  0, 0,    0,           0, 'h0,         0);
    vecs[5]  = mk(1, 'h04,  0, 0,    0,           0, 'h0,         0);
    vecs[6]  = mk(1, 'h08,  0, 0,    0,           1, 'h1111_1111, 0);
    vecs[7]  = mk(1, 'h0C,  0, 0,    0,           1, 'h2222_2222, 0);
    vecs[8]  = mk(0, 0,     0, 0,    0,           1, 'h3333_3333, 0);
    vecs[9]  = mk(0, 0,     0, 0,    0,           1, 'h4444_4444, 0);
    vecs[10] = mk(1, 'h08,  1, 'h08, 'hCAFE_F00D, 0, 'h4444_4444, 0);
    vecs[11] = mk(1, 'h08,  0, 0,    0,           0, 'h4444_4444, 0);
    vecs[12] = mk(0, 0,     0, 0,    0,           1, 'h3333_3333, 0);
    vecs[13] = mk(0, 0,     0, 0,    0,           1, 'hCAFE_F00D, 0);
    vecs[14] = mk(1, 'h400, 1, 'h02, 'h5555_5555, 0, 'hCAFE_F00D, 0);
    vecs[15] = mk(1, 'h00,  0, 0,    0,           0, 'hCAFE_F00D, 1);
    vecs[16] = mk(0, 0,     0, 0,    0,           1, 'hDEAD_BEEF, 1);
    vecs[17] = mk(0, 0,     0, 0,    0,           1, 'h1111_1111, 1);
    vecs[18] = mk(0, 0,     0, 0,    0,           0, 'h1111_1111, 1);

    repeat (2) @(posedge iClk);
    iRst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check("reset_dv",    32'(dv_a),  32'(0));
    check("reset_rdata", rd_a,       32'h0);
    check("reset_err",   32'(err_a), 32'(0));
    check("reset_rcnt",  32'(rc_a),  32'(0));
    check("reset_wcnt",  32'(wc_c),  32'(0));

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rd, vecs[i].raddr, vecs[i].wr, vecs[i].waddr, vecs[i].wdata, 0);
      check($sformatf("vec%0d_waitr", i), 32'(wr_a),  32'(0));
      check($sformatf("vec%0d_waitw", i), 32'(ww_a),  32'(0));
      check($sformatf("vec%0d_dv", i),    32'(dv_a),  32'(vecs[i].exp_dv));
      check($sformatf("vec%0d_rdata", i), rd_a,       vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i),   32'(err_a), 32'(vecs[i].exp_err));
    end
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    check("a_wcnt",       32'(wc_a),  32'(6));
    check("a_rcnt",       32'(rc_a),  32'(8));
    check("a_err_sticky", 32'(err_a), 32'(1));

    // Write wait states: two stalled cycles, accept on the third.
    iRst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    iRst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 'h10, 'hABCD_0123, 0);
      check($sformatf("b_waitw%0d", i), 32'(ww_b), 32'(i < 2));
    end
    // Read held: iStall for 2 cycles freezes the wait counter, then 3 wait cycles, accept.
    for (int i = 0; i < 8; i++) begin
      drive(i < 6, 'h10, 0, 0, 0, i < 2);
      if (i == 0) check("b_wcnt", 32'(wc_b), 32'(1));
      check($sformatf("b_waitr%0d", i), 32'(wr_b), 32'(i < 5));
      check($sformatf("b_dv%0d", i),    32'(dv_b), 32'(i == 7));
    end
    check("b_rdata", rd_b, 32'hABCD_0123);
    // Dropping iRead while waiting restarts the wait count.
    begin
      logic [6:0] exp_w;
      exp_w = 7'b0111011;
      for (int i = 0; i < 7; i++) begin
        drive(i != 2, 'h10, 0, 0, 0, 0);
        check($sformatf("b_drop_waitr%0d", i), 32'(wr_b), 32'(exp_w[i]));
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    check("b_rcnt", 32'(rc_b), 32'(2));

    // One outstanding read, latency 4: accept every 4th cycle, reusing the slot on valid.
    iRst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    iRst = 1'b0;
    for (int c = 0; c < 13; c++) begin
      drive(1, 'h04, 0, 0, 0, 0);
      check($sformatf("c_waitr%0d", c), 32'(wr_c), 32'(c % 4 != 0));
      check($sformatf("c_dv%0d", c),    32'(dv_c), 32'(c >= 4 && c % 4 == 0));
      if (c >= 4 && c % 4 == 0) check($sformatf("c_rdata%0d", c), rd_c, 32'h2222_2222);
    end
    drive(0, 0, 0, 0, 0, 0);
    check("c_rcnt", 32'(rc_c), 32'(4));

    // Reset with two reads in flight: no valids afterwards, memory retained.
    drive(1, 'h00, 0, 0, 0, 0);
    drive(1, 'h04, 0, 0, 0, 0);
    iRst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    iRst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      check($sformatf("rst_dv%0d", i), 32'(dv_a), 32'(0));
    end
    check("rst_rcnt",  32'(rc_a),  32'(0));
    check("rst_wcnt",  32'(wc_a),  32'(0));
    check("rst_err",   32'(err_a), 32'(0));
    check("rst_rdata", rd_a,       32'h0);
    drive(1, 'h00, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("rst_mem_dv",    32'(dv_a), 32'(1));
    check("rst_mem_rdata", rd_a,      32'h1111_1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
